ctrl_decode_pipe: RTL and testbench

CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

---
 rtl/ctrl_decode_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: single-stage RV32I control decoder. The decoded control
// bundle, instruction and PC are held in a valid/ready output register. The
// block stalls on load-use hazards, supports flush and keeps saturating
// stall/illegal event counters.
module ctrl_decode_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter bit          CSR_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    input  logic             ex_load_valid,
    input  logic [4:0]       ex_load_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic             we,
    output logic             alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [3:0]       alu_sel,
    output logic             br_un,
    output logic [3:0]       ld_sel,
    output logic             dmem_en,
    output logic [3:0]       dmem_we,
    output logic [1:0]       wdata_sel,
    output logic             pc_sel,
    output logic [2:0]       bresult_sel,
    output logic             rs_type,
    output logic [1:0]       csr_op,
    output logic [11:0]      csr_addr,
    output logic [XLEN-1:0]  csr_imm,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_e;

    typedef struct packed {
        logic        we;
        logic        alu_a_sel;
        logic [1:0]  alu_b_sel;
        logic [3:0]  alu_sel;
        logic        br_un;
        logic [3:0]  ld_sel;
        logic        dmem_en;
        logic [3:0]  dmem_we;
        logic [1:0]  wdata_sel;
        logic        pc_sel;
        logic [2:0]  bresult_sel;
        logic        rs_type;
        logic [1:0]  csr_op;
        logic [11:0] csr_addr;
        logic        illegal;
    } ctl_t;

    // ALU function from funct3; inst[30] selects SUB only for register ops.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_e a;
        case (f3)
            3'b000:  a = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = alt ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    // Drop the side-effecting fields so a bubble cannot write state.
    function automatic ctl_t quiesce(input ctl_t c);
        ctl_t r;
        r         = c;
        r.we      = 1'b0;
        r.dmem_en = 1'b0;
        r.dmem_we = '0;
        r.pc_sel  = 1'b0;
        return r;
    endfunction

    opcode_e         op;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    ctl_t            dec;
    logic [XLEN-1:0] dec_imm;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            hazard;
    logic            accept;

    ctl_t            ctl_q, ctl_d;
    logic [XLEN-1:0] csr_imm_q, csr_imm_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    assign op     = opcode_e'(in_inst[6:0]);
    assign funct3 = in_inst[14:12];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];

    // Combinational decode of the incoming instruction into the control bundle.
    always_comb begin
        dec      = '0;
        dec_imm  = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (op)
            OP_REG: begin
                dec.we        = 1'b1;
                dec.alu_b_sel = 2'd1;
                dec.rs_type   = 1'b1;
                dec.alu_sel   = alu_op(funct3, in_inst[30], 1'b1);
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_IMM: begin
                dec.we      = 1'b1;
                dec.alu_sel = alu_op(funct3, in_inst[30], 1'b0);
                uses_rs1    = 1'b1;
            end
            OP_STORE: begin
                dec.dmem_en = 1'b1;
                dec.rs_type = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                case (funct3)
                    3'b000:  dec.dmem_we = 4'b0001;
                    3'b001:  dec.dmem_we = 4'b0011;
                    3'b010:  dec.dmem_we = 4'b1111;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec.we        = 1'b1;
                dec.dmem_en   = 1'b1;
                dec.wdata_sel = 2'd1;
                uses_rs1      = 1'b1;
                case (funct3)
                    3'b000:  dec.ld_sel = 4'b0001;
                    3'b001:  dec.ld_sel = 4'b0011;
                    3'b010:  dec.ld_sel = 4'b1111;
                    3'b100:  dec.ld_sel = 4'b0101;
                    3'b101:  dec.ld_sel = 4'b0111;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                dec.pc_sel    = 1'b1;
                dec.alu_b_sel = 2'd1;
                dec.br_un     = in_inst[13];
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                case (funct3)
                    3'b000:         dec.bresult_sel = 3'b001;
                    3'b001:         dec.bresult_sel = 3'b011;
                    3'b100, 3'b110: dec.bresult_sel = 3'b101;
                    3'b101, 3'b111: dec.bresult_sel = 3'b111;
                    default:        dec.illegal     = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.we        = 1'b1;
                dec.alu_a_sel = 1'b1;
                dec.alu_b_sel = 2'd3;
                dec.pc_sel    = 1'b1;
            end
            OP_JALR: begin
                dec.we        = 1'b1;
                dec.alu_a_sel = 1'b1;
                dec.alu_b_sel = 2'd2;
                dec.pc_sel    = 1'b1;
                uses_rs1      = 1'b1;
            end
            OP_LUI: begin
                dec.we      = 1'b1;
                dec.alu_sel = ALU_LUI;
            end
            OP_AUIPC: begin
                dec.we        = 1'b1;
                dec.alu_a_sel = 1'b1;
            end
            OP_SYSTEM: begin
                if (CSR_EN && (funct3[1:0] != 2'b00)) begin
                    dec.we        = 1'b1;
                    dec.wdata_sel = 2'd2;
                    dec.csr_op    = funct3[1:0];
                    dec.csr_addr  = in_inst[31:20];
                    if (funct3[2]) begin
                        dec_imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
                    end else begin
                        uses_rs1 = 1'b1;
                    end
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal encodings collapse to an inert bundle carrying only the flag.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec_imm     = '0;
        end
    end

    assign hazard = in_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((uses_rs1 && (ex_load_rd == rs1)) || (uses_rs2 && (ex_load_rd == rs2)));
    assign in_ready = !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Output-register next state: flush beats accept, accept beats drain.
    always_comb begin
        valid_d   = valid_q;
        ctl_d     = ctl_q;
        csr_imm_d = csr_imm_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            ctl_d   = quiesce(ctl_q);
        end else if (accept) begin
            valid_d   = 1'b1;
            ctl_d     = dec;
            csr_imm_d = dec_imm;
            inst_d    = in_inst;
            pc_d      = in_pc;
        end else if (out_ready) begin
            valid_d = 1'b0;
            ctl_d   = quiesce(ctl_q);
        end
    end

    // Saturating event counters; a flushed accept is not counted as executed.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        ill_cnt_d   = ill_cnt_q;
        if (hazard && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (accept && !flush && dec.illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            ctl_q       <= '0;
            csr_imm_q   <= '0;
            inst_q      <= '0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
            ill_cnt_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            ctl_q       <= ctl_d;
            csr_imm_q   <= csr_imm_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_inst    = inst_q;
    assign out_pc      = pc_q;
    assign we          = ctl_q.we;
    assign alu_a_sel   = ctl_q.alu_a_sel;
    assign alu_b_sel   = ctl_q.alu_b_sel;
    assign alu_sel     = ctl_q.alu_sel;
    assign br_un       = ctl_q.br_un;
    assign ld_sel      = ctl_q.ld_sel;
    assign dmem_en     = ctl_q.dmem_en;
    assign dmem_we     = ctl_q.dmem_we;
    assign wdata_sel   = ctl_q.wdata_sel;
    assign pc_sel      = ctl_q.pc_sel;
    assign bresult_sel = ctl_q.bresult_sel;
    assign rs_type     = ctl_q.rs_type;
    assign csr_op      = ctl_q.csr_op;
    assign csr_addr    = ctl_q.csr_addr;
    assign csr_imm     = csr_imm_q;
    assign illegal     = ctl_q.illegal;
    assign stall_cnt   = stall_cnt_q;
    assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: directed table of decode vectors plus hand-written
// sequences for backpressure, load-use stall, flush, reset and saturation.
module tb_ctrl_decode_pipe;

    typedef struct packed {
        logic        we;
        logic        alu_a_sel;
        logic [1:0]  alu_b_sel;
        logic [3:0]  alu_sel;
        logic        br_un;
        logic [3:0]  ld_sel;
        logic        dmem_en;
        logic [3:0]  dmem_we;
        logic [1:0]  wdata_sel;
        logic        pc_sel;
        logic [2:0]  bresult_sel;
        logic        rs_type;
        logic [1:0]  csr_op;
        logic [11:0] csr_addr;
        logic [31:0] csr_imm;
        logic        illegal;
    } ctl_t;

    typedef struct {
        logic [31:0] inst;
        ctl_t        exp;
    } tv_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance (CSR_EN=1) stimulus and outputs.
    logic        in_valid, in_ready, flush, ex_load_valid, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_inst, out_pc, csr_imm;
    logic [4:0]  ex_load_rd;
    logic        we, alu_a_sel, br_un, dmem_en, pc_sel, rs_type, illegal;
    logic [1:0]  alu_b_sel, wdata_sel, csr_op;
    logic [3:0]  alu_sel, ld_sel, dmem_we;
    logic [2:0]  bresult_sel;
    logic [11:0] csr_addr;
    logic [15:0] stall_cnt, illegal_cnt;
    ctl_t        act;

    // Second instance with CSR decode disabled.
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [31:0] n_in_inst, n_out_inst, n_out_pc, n_csr_imm;
    logic        n_we, n_alu_a_sel, n_br_un, n_dmem_en, n_pc_sel, n_rs_type, n_illegal;
    logic [1:0]  n_alu_b_sel, n_wdata_sel, n_csr_op;
    logic [3:0]  n_alu_sel, n_ld_sel, n_dmem_we;
    logic [2:0]  n_bresult_sel;
    logic [11:0] n_csr_addr;
    logic [15:0] n_stall_cnt, n_illegal_cnt;
    ctl_t        n_act;

    ctrl_decode_pipe #(.XLEN(32), .CSR_EN(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .we(we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_sel(alu_sel),
        .br_un(br_un), .ld_sel(ld_sel), .dmem_en(dmem_en), .dmem_we(dmem_we),
        .wdata_sel(wdata_sel), .pc_sel(pc_sel), .bresult_sel(bresult_sel), .rs_type(rs_type),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_imm(csr_imm), .illegal(illegal),
        .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt)
    );

    ctrl_decode_pipe #(.XLEN(32), .CSR_EN(1'b0), .CNT_W(16)) u_nocsr (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_inst(n_in_inst), .in_pc(32'h0000_0200), .flush(1'b0),
        .ex_load_valid(1'b0), .ex_load_rd(5'd0),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_inst(n_out_inst), .out_pc(n_out_pc),
        .we(n_we), .alu_a_sel(n_alu_a_sel), .alu_b_sel(n_alu_b_sel), .alu_sel(n_alu_sel),
        .br_un(n_br_un), .ld_sel(n_ld_sel), .dmem_en(n_dmem_en), .dmem_we(n_dmem_we),
        .wdata_sel(n_wdata_sel), .pc_sel(n_pc_sel), .bresult_sel(n_bresult_sel), .rs_type(n_rs_type),
        .csr_op(n_csr_op), .csr_addr(n_csr_addr), .csr_imm(n_csr_imm), .illegal(n_illegal),
        .stall_cnt(n_stall_cnt), .illegal_cnt(n_illegal_cnt)
    );

    assign act = {we, alu_a_sel, alu_b_sel, alu_sel, br_un, ld_sel, dmem_en, dmem_we,
                  wdata_sel, pc_sel, bresult_sel, rs_type, csr_op, csr_addr, csr_imm, illegal};
    assign n_act = {n_we, n_alu_a_sel, n_alu_b_sel, n_alu_sel, n_br_un, n_ld_sel, n_dmem_en,
                    n_dmem_we, n_wdata_sel, n_pc_sel, n_bresult_sel, n_rs_type, n_csr_op,
                    n_csr_addr, n_csr_imm, n_illegal};

    int   n_chk = 0;
    int   n_fail = 0;
    tv_t  tv[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] i, input ctl_t e);
        tv_t r;
        r.inst = i;
        r.exp  = e;
        tv.push_back(r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t e_sub, e_add, e_and, e_sltiu, e_lui, e_ill;
        int unsigned exp_ill;
        int unsigned n_tv;

        e_sub   = '{we:1'b1, alu_b_sel:2'd1, alu_sel:4'd1, rs_type:1'b1, default:'0};
        e_add   = '{we:1'b1, alu_b_sel:2'd1, rs_type:1'b1, default:'0};
        e_and   = '{we:1'b1, alu_b_sel:2'd1, alu_sel:4'd9, rs_type:1'b1, default:'0};
        e_sltiu = '{we:1'b1, alu_sel:4'd4, default:'0};
        e_lui   = '{we:1'b1, alu_sel:4'd10, default:'0};
        e_ill   = '{illegal:1'b1, default:'0};

        add(32'h40B50533, e_sub);
        add(32'h00728333, e_add);
        add(32'h403150B3, '{we:1'b1, alu_b_sel:2'd1, alu_sel:4'd7, rs_type:1'b1, default:'0});
        add(32'h003170B3, e_and);
        add(32'hFFF10093, '{we:1'b1, default:'0});
        add(32'h40315093, '{we:1'b1, alu_sel:4'd7, default:'0});
        add(32'h00315093, '{we:1'b1, alu_sel:4'd6, default:'0});
        add(32'h00513093, e_sltiu);
        add(32'h00312423, '{dmem_en:1'b1, dmem_we:4'b1111, rs_type:1'b1, default:'0});
        add(32'h00310023, '{dmem_en:1'b1, dmem_we:4'b0001, rs_type:1'b1, default:'0});
        add(32'h00313023, e_ill);
        add(32'h00015083, '{we:1'b1, dmem_en:1'b1, wdata_sel:2'd1, ld_sel:4'b0111, default:'0});
        add(32'h00012083, '{we:1'b1, dmem_en:1'b1, wdata_sel:2'd1, ld_sel:4'b1111, default:'0});
        add(32'h00013083, e_ill);
        add(32'h00208063, '{pc_sel:1'b1, alu_b_sel:2'd1, bresult_sel:3'b001, default:'0});
        add(32'h0020F063, '{pc_sel:1'b1, alu_b_sel:2'd1, br_un:1'b1, bresult_sel:3'b111, default:'0});
        add(32'h0020E063, '{pc_sel:1'b1, alu_b_sel:2'd1, br_un:1'b1, bresult_sel:3'b101, default:'0});
        add(32'h0020C063, '{pc_sel:1'b1, alu_b_sel:2'd1, bresult_sel:3'b101, default:'0});
        add(32'h0020A063, e_ill);
        add(32'h000000EF, '{we:1'b1, alu_a_sel:1'b1, alu_b_sel:2'd3, pc_sel:1'b1, default:'0});
        add(32'h000100E7, '{we:1'b1, alu_a_sel:1'b1, alu_b_sel:2'd2, pc_sel:1'b1, default:'0});
        add(32'h123450B7, e_lui);
        add(32'h00000097, '{we:1'b1, alu_a_sel:1'b1, default:'0});
        add(32'h3003D0F3, '{we:1'b1, wdata_sel:2'd2, csr_op:2'd1, csr_addr:12'h300, csr_imm:32'd7, default:'0});
        add(32'h300120F3, '{we:1'b1, wdata_sel:2'd2, csr_op:2'd2, csr_addr:12'h300, default:'0});
        add(32'h3402B073, '{we:1'b1, wdata_sel:2'd2, csr_op:2'd3, csr_addr:12'h340, default:'0});
        add(32'h00000073, e_ill);
        add(32'h0000007F, e_ill);
        add(32'h00000000, e_ill);

        in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
        ex_load_valid = 1'b0; ex_load_rd = '0; out_ready = 1'b0;
        n_in_valid = 1'b0; n_in_inst = '0; n_out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ctl", act, '0);
        chk("rst_out_inst", out_inst, '0);
        chk("rst_out_pc", out_pc, '0);
        chk("rst_stall_cnt", stall_cnt, '0);
        chk("rst_illegal_cnt", illegal_cnt, '0);
        chk("rst_nocsr_valid", n_out_valid, 1'b0);

        // First accept right after reset release (sub x10,x10,x11)
        rst_n = 1'b1;
        in_inst = 32'h40B50533; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("first_in_ready", in_ready, 1'b1);
        step();
        chk("first_out_valid", out_valid, 1'b1);
        chk("first_ctl", act, e_sub);
        chk("first_out_inst", out_inst, 32'h40B50533);
        chk("first_out_pc", out_pc, 32'h100);

        // Backpressure: out_ready low for 3 cycles while a new instruction waits
        in_inst = 32'h003170B3; in_pc = 32'h104;
        step();
        chk("bp_a_inst", out_inst, 32'h003170B3);
        out_ready = 1'b0;
        in_inst = 32'h00513093; in_pc = 32'h108;
        #1 chk("bp_in_ready_low", in_ready, 1'b0);
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_hold_valid%0d", k), out_valid, 1'b1);
            chk($sformatf("bp_hold_inst%0d", k), out_inst, 32'h003170B3);
            chk($sformatf("bp_hold_ctl%0d", k), act, e_and);
            chk($sformatf("bp_hold_pc%0d", k), out_pc, 32'h104);
            chk($sformatf("bp_in_ready%0d", k), in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", in_ready, 1'b1);
        step();
        chk("bp_b_inst", out_inst, 32'h00513093);
        chk("bp_b_ctl", act, e_sltiu);
        in_inst = 32'h123450B7; in_pc = 32'h10C;
        step();
        chk("bp_c_inst", out_inst, 32'h123450B7);
        chk("bp_c_ctl", act, e_lui);
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 1'b0);
        chk("drain_we", we, 1'b0);

        // Load-use hazard on rs1 (add x6,x5,x7 with load to x5)
        ex_load_valid = 1'b1; ex_load_rd = 5'd5;
        in_inst = 32'h00728333; in_pc = 32'h110; in_valid = 1'b1;
        #1 chk("haz_rs1_in_ready", in_ready, 1'b0);
        step();
        chk("haz_rs1_bubble", out_valid, 1'b0);
        chk("haz_rs1_stall_cnt", stall_cnt, 16'd1);
        ex_load_rd = 5'd0;
        #1 chk("haz_x0_in_ready", in_ready, 1'b1);
        step();
        chk("haz_x0_valid", out_valid, 1'b1);
        chk("haz_x0_inst", out_inst, 32'h00728333);
        chk("haz_x0_stall_cnt", stall_cnt, 16'd1);
        ex_load_rd = 5'd7;
        #1 chk("haz_rs2_in_ready", in_ready, 1'b0);
        step();
        chk("haz_rs2_bubble", out_valid, 1'b0);
        chk("haz_rs2_bubble_we", we, 1'b0);
        chk("haz_rs2_stall_cnt", stall_cnt, 16'd2);
        ex_load_valid = 1'b0; ex_load_rd = 5'd0;

        // Flush coincident with an accept
        in_inst = 32'h123450B7; in_pc = 32'h114; flush = 1'b1;
        #1 chk("flush_in_ready", in_ready, 1'b1);
        step();
        chk("flush_accept_valid", out_valid, 1'b0);
        flush = 1'b0;
        in_inst = 32'h003170B3; in_pc = 32'h118;
        step();
        chk("post_flush_valid", out_valid, 1'b1);
        chk("post_flush_inst", out_inst, 32'h003170B3);
        // Flush of a held instruction under backpressure
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        step();
        chk("flush_held_valid", out_valid, 1'b0);
        chk("flush_held_we", we, 1'b0);
        // A hazard during flush is not counted as a stall
        ex_load_valid = 1'b1; ex_load_rd = 5'd5; in_inst = 32'h00728333; in_valid = 1'b1;
        step();
        chk("flush_haz_stall_cnt", stall_cnt, 16'd2);
        chk("flush_haz_valid", out_valid, 1'b0);
        flush = 1'b0; ex_load_valid = 1'b0; ex_load_rd = 5'd0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // CSR instruction on the CSR_EN=0 instance
        n_in_inst = 32'h3003D0F3; n_in_valid = 1'b1; n_out_ready = 1'b1;
        step();
        n_in_valid = 1'b0;
        chk("nocsr_valid", n_out_valid, 1'b1);
        chk("nocsr_ctl", n_act, e_ill);
        chk("nocsr_illegal_cnt", n_illegal_cnt, 16'd1);

        // Decode table, streamed back-to-back
        exp_ill = 0;
        n_tv = tv.size();
        for (int unsigned i = 0; i < n_tv; i++) begin
            in_inst = tv[i].inst; in_pc = 32'h1000 + (i * 4); in_valid = 1'b1;
            step();
            chk($sformatf("tv%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("tv%0d_ctl", i), act, tv[i].exp);
            chk($sformatf("tv%0d_inst", i), out_inst, tv[i].inst);
            chk($sformatf("tv%0d_pc", i), out_pc, 32'h1000 + (i * 4));
            if (tv[i].exp.illegal) exp_ill++;
        end
        in_valid = 1'b0;
        step();
        chk("tbl_drain_valid", out_valid, 1'b0);
        chk("tbl_illegal_cnt", illegal_cnt, exp_ill);
        chk("tbl_stall_cnt", stall_cnt, 16'd2);

        // Asynchronous reset in the middle of a stream
        in_inst = 32'h123450B7; in_pc = 32'h2000; in_valid = 1'b1;
        step();
        chk("mid_pre_valid", out_valid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ctl", act, '0);
        chk("mid_rst_inst", out_inst, '0);
        chk("mid_rst_pc", out_pc, '0);
        chk("mid_rst_stall_cnt", stall_cnt, '0);
        chk("mid_rst_illegal_cnt", illegal_cnt, '0);
        chk("mid_rst_nocsr_cnt", n_illegal_cnt, '0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", out_valid, 1'b0);

        // illegal_cnt saturation
        in_inst = 32'h00000000; in_valid = 1'b1; out_ready = 1'b1;
        for (int unsigned i = 0; i < 65534; i++) step();
        chk("sat_fffe", illegal_cnt, 16'hFFFE);
        step();
        chk("sat_ffff", illegal_cnt, 16'hFFFF);
        repeat (3) step();
        chk("sat_hold", illegal_cnt, 16'hFFFF);
        chk("sat_ctl", act, e_ill);
        in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
